// File: rtl/buffer_1clk.sv
// Single-clock elastic FIFO between avail/ready producer and consumer.
// Arbitrary depth, optional registered output stage, sync flush, level and threshold flags.
module buffer_1clk #(
  parameter int WIDTH         = 8,
  parameter int DEPTH         = 4,
  parameter int OUT_REG       = 0,
  parameter int AFULL_THRESH  = DEPTH - 1,
  parameter int AEMPTY_THRESH = 1,
  localparam int CAP          = DEPTH + OUT_REG,
  localparam int LW           = $clog2(CAP + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] wdata_in,
  input  logic             wavail_in,
  output logic             wready_in,
  output logic [WIDTH-1:0] rdata_out,
  output logic             ravail_out,
  input  logic             rready_out,
  input  logic             flush,
  output logic [LW-1:0]    level,
  output logic             almost_full,
  output logic             almost_empty
);

  localparam int              PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [31:0]     AF_T  = 32'(AFULL_THRESH);
  localparam logic [31:0]     AE_T  = 32'(AEMPTY_THRESH);
  localparam logic [LW-1:0]   CAP_L = LW'(CAP);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wptr;
  logic             wr_fire;
  logic             rd_fire;
  logic [LW-1:0]    level_next;

  // Pointers wrap explicitly so any DEPTH works, not only powers of two.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Acceptance depends only on registered occupancy; reset holds it low.
  assign wready_in = rst & (level < CAP_L);
  assign wr_fire   = wavail_in & wready_in & ~flush;
  assign rd_fire   = ravail_out & rready_out & ~flush;

  // NOTE: the storage array is deliberately left unreset; valid data is tracked
  // by the pointers and level alone, so clearing it would only cost reset fanout.
  always_ff @(posedge clk) begin
    if (wr_fire) mem[wptr] <= wdata_in;
  end

  // NOTE: state is updated with non-blocking assignments so every register
  // samples the values from before the edge, independent of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)       wptr <= '0;
    else if (flush) wptr <= '0;
    else if (wr_fire) wptr <= ptr_inc(wptr);
  end

  // Level and both flags come from the same next-state value, so they never disagree.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      level        <= '0;
      almost_full  <= 1'b0;
      almost_empty <= 1'b1;
    end else begin
      level        <= level_next;
      almost_full  <= (32'(level_next) >= AF_T);
      almost_empty <= (32'(level_next) <= AE_T);
    end
  end

  if (OUT_REG != 0) begin : g_out_reg
    logic [PW-1:0]    rptr;
    logic [LW-1:0]    ram_count;
    logic [LW-1:0]    ram_next;
    logic             out_valid;
    logic             out_valid_next;
    logic             refill;
    logic [WIDTH-1:0] out_data;

    // The output stage loads from RAM only; a word written this cycle is not yet eligible.
    assign refill = (~out_valid | rd_fire) & (ram_count != '0) & ~flush;

    // NOTE: every signal driven here gets a default first, so no path leaves
    // it unassigned and no latch is inferred.
    always_comb begin
      ram_next       = ram_count;
      out_valid_next = out_valid;
      if (flush) begin
        ram_next       = '0;
        out_valid_next = 1'b0;
      end else begin
        ram_next = ram_count + LW'(wr_fire) - LW'(refill);
        if (refill)       out_valid_next = 1'b1;
        else if (rd_fire) out_valid_next = 1'b0;
      end
    end

    assign level_next = ram_next + LW'(out_valid_next);

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        rptr      <= '0;
        ram_count <= '0;
        out_valid <= 1'b0;
        out_data  <= '0;
      end else if (flush) begin
        rptr      <= '0;
        ram_count <= '0;
        out_valid <= 1'b0;
        out_data  <= '0;
      end else begin
        ram_count <= ram_next;
        out_valid <= out_valid_next;
        if (refill) begin
          out_data <= mem[rptr];
          rptr     <= ptr_inc(rptr);
        end
      end
    end

    assign rdata_out  = out_data;
    assign ravail_out = out_valid;
  end else begin : g_fwft
    logic [PW-1:0] rptr;

    always_ff @(posedge clk or negedge rst) begin
      if (!rst)         rptr <= '0;
      else if (flush)   rptr <= '0;
      else if (rd_fire) rptr <= ptr_inc(rptr);
    end

    // First-word-fall-through: head entry is presented straight from the array.
    assign rdata_out  = mem[rptr];
    assign ravail_out = (level != '0);
    assign level_next = flush ? '0 : (level + LW'(wr_fire) - LW'(rd_fire));
  end

  level_in_range: assert property (@(posedge clk) disable iff (!rst) level <= CAP_L);

endmodule
